code_patch_engine: RTL

// - Multi-entry ROM code-patch unit in the instruction fetch path.
// - Holds NUM_PATCH {enable, address, data} entries. A fetch whose address matches an enabled entry

---
 rtl/code_patch_engine.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/code_patch_engine.sv
// ROM code-patch unit for the instruction fetch path: NUM_PATCH address/data overrides,
// a table-clear sweep and a pattern-generator mode that replaces fetch data with a counter.
module code_patch_engine #(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 22,
   parameter int NUM_PATCH = 4,
   parameter int IDX_W     = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_wr_valid_i,
   output logic              cfg_wr_ready_o,
   input  logic [IDX_W-1:0]  cfg_wr_idx_i,
   input  logic              cfg_wr_en_i,
   input  logic [ADDR_W-1:0] cfg_wr_addr_i,
   input  logic [DATA_W-1:0] cfg_wr_data_i,
   input  logic              cfg_clr_i,
   input  logic              cfg_pat_gen_i,
   input  logic              si_read_i,
   input  logic              fetch_valid_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              fetch_valid_o,
   output logic [DATA_W-1:0] fetch_data_o,
   output logic              patch_hit_o,
   output logic              nopg_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_PATGEN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    sweep_q, sweep_d;
   logic [NUM_PATCH-1:0] en_q, en_d;
   logic [ADDR_W-1:0]   addr_q [NUM_PATCH];
   logic [DATA_W-1:0]   data_q [NUM_PATCH];
   logic [DATA_W-1:0]   pat_q, pat_d;
   logic                fvalid_q;
   logic [DATA_W-1:0]   fdata_q, fdata_d;
   logic                fhit_q, fhit_d;
   logic                nopg_q, nopg_d;

   logic                wr_ready;
   logic                wr_fire;
   logic                hit;
   logic [DATA_W-1:0]   hit_data;

   // Ready is held low while reset is asserted even though the state already reads IDLE.
   assign wr_ready = rst_ni & (state_q == ST_IDLE) & ~si_read_i;
   assign wr_fire  = cfg_wr_valid_i & wr_ready;

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_clr_i) begin
               state_d = ST_CLEAR;
               sweep_d = '0;
            end else if (cfg_pat_gen_i) begin
               state_d = ST_PATGEN;
            end
         end
         ST_CLEAR: begin
            if (sweep_q == IDX_W'(NUM_PATCH - 1)) begin
               state_d = ST_IDLE;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         ST_PATGEN: begin
            if (cfg_clr_i) begin
               state_d = ST_CLEAR;
               sweep_d = '0;
            end else if (!cfg_pat_gen_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sweep_d = '0;
         end
      endcase
   end

   always_comb begin
      en_d = en_q;
      for (int k = 0; k < NUM_PATCH; k++) begin
         if (state_q == ST_CLEAR && sweep_q == IDX_W'(k)) en_d[k] = 1'b0;
         if (wr_fire && cfg_wr_idx_i == IDX_W'(k))        en_d[k] = cfg_wr_en_i;
      end
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = NUM_PATCH - 1; k >= 0; k--) begin
         if (en_q[k] && addr_q[k] == fetch_addr_i) begin
            hit      = 1'b1;
            hit_data = data_q[k];
         end
      end
   end

   always_comb begin
      fdata_d = fdata_q;
      fhit_d  = fhit_q;
      pat_d   = pat_q;
      if (fetch_valid_i) begin
         if (state_q == ST_PATGEN) begin
            fdata_d = pat_q;
            fhit_d  = 1'b0;
            pat_d   = pat_q + 1'b1;
         end else begin
            fdata_d = hit ? hit_data : rom_data_i;
            fhit_d  = hit;
         end
      end
   end

   assign nopg_d = ~(|en_q) & (state_q != ST_PATGEN);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         sweep_q  <= '0;
         en_q     <= '0;
         pat_q    <= '0;
         fvalid_q <= 1'b0;
         fdata_q  <= '0;
         fhit_q   <= 1'b0;
         nopg_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         sweep_q  <= sweep_d;
         en_q     <= en_d;
         pat_q    <= pat_d;
         fvalid_q <= fetch_valid_i;
         fdata_q  <= fdata_d;
         fhit_q   <= fhit_d;
         nopg_q   <= nopg_d;
      end
   end

   // Match fields carry no reset; an entry is only visible through its enable bit.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NUM_PATCH; k++) begin
         if (wr_fire && cfg_wr_idx_i == IDX_W'(k)) begin
            addr_q[k] <= cfg_wr_addr_i;
            data_q[k] <= cfg_wr_data_i;
         end
      end
   end

   assign cfg_wr_ready_o = wr_ready;
   assign fetch_valid_o  = fvalid_q;
   assign fetch_data_o   = fdata_q;
   assign patch_hit_o    = fhit_q;
   assign nopg_o         = nopg_q;

endmodule
